// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: synchronises the front-panel buttons and switches,
// debounces the buttons, runs the IDLE/RUN/PAUSED/ADJUST state machine and
// turns the divider's 1 Hz / 2 Hz levels into single-cycle count enables.
module stopwatch_ctrl #(
  parameter int unsigned DB_CYCLES = 2_000_000,
  parameter int unsigned DB_W      = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  input  logic       clk_1Hz,
  input  logic       clk_2Hz,
  output logic [1:0] state,
  output logic       run,
  output logic       adj_mode,
  output logic       sel_out,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       clear_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_ADJUST = 2'b11
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit order of the synchroniser bank
  localparam int unsigned B_PAUSE = 0;
  localparam int unsigned B_CLEAR = 1;
  localparam int unsigned B_ADJ   = 2;
  localparam int unsigned B_SEL   = 3;

  logic [5:0]      w_async;
  logic [5:0]      r_meta;
  logic [5:0]      r_sync;
  logic [DB_W-1:0] r_db_cnt [2];
  logic [1:0]      r_db_lvl;
  logic [1:0]      r_press;
  logic [1:0]      r_clk_prev;
  logic [1:0]      r_tick;

  state_t          r_state;
  logic            r_run;
  logic            r_adj;
  logic            r_sel;
  logic            r_inc_sec;
  logic            r_inc_min;
  logic            r_clear;

  state_t          w_next;
  logic            w_inc_sec;
  logic            w_inc_min;
  logic            w_clear;
  logic            w_adj;

  assign w_async = {clk_2Hz, clk_1Hz, sw_sel, sw_adj, btn_clear, btn_pause};
  assign w_adj   = r_sync[B_ADJ];

  // Two-flop synchroniser for every asynchronous input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_async;
      r_sync <= r_meta;
    end
  end

  // Button debounce: accept a new level after DB_CYCLES cycles of disagreement,
  // and flag a one-cycle press on an accepted 0->1 change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
      r_db_lvl <= '0;
      r_press  <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync[i] != r_db_lvl[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_db_lvl[i] <= r_sync[i];
            r_db_cnt[i] <= '0;
            r_press[i]  <= r_sync[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Registered rising-edge detect on the synchronised 1 Hz / 2 Hz levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_prev <= '0;
      r_tick     <= '0;
    end else begin
      r_clk_prev <= r_sync[5:4];
      r_tick     <= r_sync[5:4] & ~r_clk_prev;
    end
  end

  // Next state and count enables, highest-priority event first; a state
  // change or clear in a cycle suppresses any increment
  always_comb begin
    w_next    = r_state;
    w_inc_sec = 1'b0;
    w_inc_min = 1'b0;
    w_clear   = 1'b0;
    if (w_adj && (r_state != S_ADJUST)) begin
      w_next = S_ADJUST;
    end else if (!w_adj && (r_state == S_ADJUST)) begin
      w_next = S_PAUSED;
    end else if (r_press[B_CLEAR]) begin
      w_clear = 1'b1;
      if (r_state != S_ADJUST) w_next = S_IDLE;
    end else if (r_press[B_PAUSE] && (r_state != S_ADJUST)) begin
      w_next = (r_state == S_RUN) ? S_PAUSED : S_RUN;
    end else if ((r_state == S_RUN) && r_tick[0]) begin
      w_inc_sec = 1'b1;
    end else if ((r_state == S_ADJUST) && r_tick[1]) begin
      w_inc_sec = r_sel;
      w_inc_min = ~r_sel;
    end
  end

  // State register with registered mode flags and pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_run     <= 1'b0;
      r_adj     <= 1'b0;
      r_sel     <= 1'b0;
      r_inc_sec <= 1'b0;
      r_inc_min <= 1'b0;
      r_clear   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_run     <= (w_next == S_RUN);
      r_adj     <= (w_next == S_ADJUST);
      r_sel     <= r_sync[B_SEL];
      r_inc_sec <= w_inc_sec;
      r_inc_min <= w_inc_min;
      r_clear   <= w_clear;
    end
  end

  assign state     = r_state;
  assign run       = r_run;
  assign adj_mode  = r_adj;
  assign sel_out   = r_sel;
  assign inc_sec   = r_inc_sec;
  assign inc_min   = r_inc_min;
  assign clear_cnt = r_clear;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DB_CYCLES=4: a history-based reference model
// compared every cycle, a table of held-input segments, directed corner cases
// and a randomized phase.
module tb_stopwatch_ctrl;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_pause, btn_clear, sw_adj, sw_sel, clk_1Hz, clk_2Hz;
  logic [1:0] state;
  logic       run, adj_mode, sel_out, inc_sec, inc_min, clear_cnt;

  stopwatch_ctrl #(.DB_CYCLES(DB), .DB_W(3)) dut (
    .clk(clk), .rst(rst),
    .btn_pause(btn_pause), .btn_clear(btn_clear),
    .sw_adj(sw_adj), .sw_sel(sw_sel),
    .clk_1Hz(clk_1Hz), .clk_2Hz(clk_2Hz),
    .state(state), .run(run), .adj_mode(adj_mode), .sel_out(sel_out),
    .inc_sec(inc_sec), .inc_min(inc_min), .clear_cnt(clear_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  // ---------------- reference model ----------------
  // h[k] holds the input sample taken k edges ago; bits {c2,c1,sel,adj,clr,pause}.
  // An input seen at edge n reaches the synchronised domain at edge n+2.
  logic [5:0] h[$];
  int         m_st;
  bit         m_db[2];
  bit         m_pr[2];
  logic [7:0] m_exp;

  task automatic model_reset();
    h.delete();
    for (int i = 0; i < 8; i++) h.push_front(6'd0);
    m_st  = 0;
    m_db[0] = 0; m_db[1] = 0;
    m_pr[0] = 0; m_pr[1] = 0;
    m_exp = 8'd0;
  endtask

  task automatic model_step(input logic [5:0] x);
    bit pp, pc, adj_s, sel_now, t1, t2, isec, imin, clr, flip;
    int nst;
    h.push_front(x);
    h.pop_back();
    pp      = m_pr[0];
    pc      = m_pr[1];
    adj_s   = h[2][2];
    sel_now = h[3][3];
    t1      = h[3][4] & ~h[4][4];
    t2      = h[3][5] & ~h[4][5];
    // A button level is accepted once DB consecutive synchronised samples
    // all disagree with the accepted level
    for (int b = 0; b < 2; b++) begin
      flip = 1;
      for (int k = 2; k < 2 + DB; k++) if (h[k][b] == m_db[b]) flip = 0;
      if (flip) m_db[b] = ~m_db[b];
      m_pr[b] = flip && m_db[b];
    end
    isec = 0; imin = 0; clr = 0; nst = m_st;
    if (adj_s && m_st != 3)       nst = 3;
    else if (!adj_s && m_st == 3) nst = 2;
    else if (pc) begin
      clr = 1;
      if (m_st != 3) nst = 0;
    end
    else if (pp && m_st != 3)     nst = (m_st == 1) ? 2 : 1;
    else if (m_st == 1 && t1)     isec = 1;
    else if (m_st == 3 && t2) begin
      if (sel_now) isec = 1; else imin = 1;
    end
    m_st  = nst;
    m_exp = {2'(nst), nst == 1, nst == 3, h[2][3], isec, imin, clr};
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step({clk_2Hz, clk_1Hz, sw_sel, sw_adj, btn_clear, btn_pause});
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({state, run, adj_mode, sel_out, inc_sec, inc_min, clear_cnt} !== m_exp) begin
        failures++;
        $display("FAIL model t=%0t got=%b exp=%b", $time,
                 {state, run, adj_mode, sel_out, inc_sec, inc_min, clear_cnt}, m_exp);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit p, c, a, s, t1, t2);
    btn_pause = p; btn_clear = c; sw_adj = a; sw_sel = s; clk_1Hz = t1; clk_2Hz = t2;
  endtask

  task automatic hold(input bit p, c, a, s, t1, t2, input int n);
    repeat (n) begin
      @(negedge clk);
      drive(p, c, a, s, t1, t2);
    end
  endtask

  typedef struct {
    bit p, c, a, s, t1, t2;
    int st, n_sec, n_min, n_clr;
  } seg_t;

  seg_t tbl[20];
  int   n_sec, n_min, n_clr, n_sec2, n_clr2;

  initial begin
    tbl[0]  = '{0,0,0,0,0,0, 0, 0,0,0};
    tbl[1]  = '{1,0,0,0,0,0, 1, 0,0,0};  // pause press: IDLE -> RUN
    tbl[2]  = '{0,0,0,0,0,0, 1, 0,0,0};  // release: no event
    tbl[3]  = '{0,0,0,0,1,0, 1, 1,0,0};  // 1 Hz rise in RUN
    tbl[4]  = '{0,0,0,0,0,0, 1, 0,0,0};
    tbl[5]  = '{1,0,0,0,0,0, 2, 0,0,0};  // RUN -> PAUSED
    tbl[6]  = '{0,0,0,0,1,0, 2, 0,0,0};  // 1 Hz rise while paused
    tbl[7]  = '{0,0,1,0,0,0, 3, 0,0,0};  // enter ADJUST
    tbl[8]  = '{0,0,1,0,0,1, 3, 0,1,0};
    tbl[9]  = '{0,0,1,0,0,0, 3, 0,0,0};
    tbl[10] = '{0,0,1,0,0,1, 3, 0,1,0};
    tbl[11] = '{0,0,1,0,0,0, 3, 0,0,0};
    tbl[12] = '{0,0,1,0,0,1, 3, 0,1,0};
    tbl[13] = '{0,0,1,1,0,0, 3, 0,0,0};  // select seconds
    tbl[14] = '{0,0,1,1,0,1, 3, 1,0,0};
    tbl[15] = '{0,0,0,1,0,0, 2, 0,0,0};  // leave ADJUST -> PAUSED
    tbl[16] = '{1,0,0,1,0,0, 1, 0,0,0};  // PAUSED -> RUN
    tbl[17] = '{0,0,0,1,0,0, 1, 0,0,0};
    tbl[18] = '{1,1,0,1,0,0, 0, 0,0,1};  // clear and pause together
    tbl[19] = '{0,0,0,1,0,0, 0, 0,0,0};

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_outputs", int'({state, run, adj_mode, sel_out, inc_sec, inc_min, clear_cnt}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;

    // ---- table of held-input segments ----
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tbl[i].p, tbl[i].c, tbl[i].a, tbl[i].s, tbl[i].t1, tbl[i].t2);
      n_sec = 0; n_min = 0; n_clr = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        n_sec += int'(inc_sec); n_min += int'(inc_min); n_clr += int'(clear_cnt);
      end
      chk($sformatf("seg%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("seg%0d_flags", i), int'({run, adj_mode}),
          (tbl[i].st == 1) ? 2 : (tbl[i].st == 3) ? 1 : 0);
      chk($sformatf("seg%0d_inc_sec", i), n_sec, tbl[i].n_sec);
      chk($sformatf("seg%0d_inc_min", i), n_min, tbl[i].n_min);
      chk($sformatf("seg%0d_clear", i), n_clr, tbl[i].n_clr);
    end

    // ---- exact button latency: IDLE -> RUN 7 cycles after press edge ----
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("btn_lat_k%0d", k), int'(state), (k >= 7) ? 1 : 0);
    end
    chk("btn_lat_run", int'(run), 1);
    hold(0, 0, 0, 0, 0, 0, 8);

    // ---- exact tick latency: inc_sec 4 cycles after 1 Hz rise ----
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tick_lat_k%0d", k), int'(inc_sec), (k == 4) ? 1 : 0);
    end
    hold(0, 0, 0, 0, 0, 0, 4);

    // ---- clear + pause together, with a 1 Hz tick landing on the same cycle ----
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0);
    n_sec2 = 0; n_clr2 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      n_sec2 += int'(inc_sec); n_clr2 += int'(clear_cnt);
      if (k == 7) begin
        chk("aligned_clear", int'(clear_cnt), 1);
        chk("aligned_no_inc", int'(inc_sec), 0);
        chk("aligned_state", int'(state), 0);
      end
      @(negedge clk);
      if (k == 3) clk_1Hz = 1'b1;
    end
    chk("aligned_sec_total", n_sec2, 0);
    chk("aligned_clr_total", n_clr2, 1);
    hold(0, 0, 0, 0, 0, 0, 10);

    // ---- 2-cycle glitch in IDLE gives nothing ----
    hold(1, 0, 0, 0, 0, 0, 2);
    hold(0, 0, 0, 0, 0, 0, 10);
    @(posedge clk); #1;
    chk("glitch_state", int'(state), 0);

    // ---- asynchronous reset mid-RUN with a tick in flight ----
    hold(1, 0, 0, 0, 0, 0, 8);
    hold(0, 0, 0, 0, 0, 0, 8);
    @(negedge clk);
    clk_1Hz = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_state", int'(state), 1);
    rst = 1'b0;
    btn_pause = 1'b1;
    #1;
    chk("async_reset_outputs",
        int'({state, run, adj_mode, sel_out, inc_sec, inc_min, clear_cnt}), 0);
    @(negedge clk);
    rst = 1'b1;
    // Button held through reset is debounced afresh and acts as a press
    n_sec2 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      n_sec2 += int'(inc_sec);
    end
    chk("post_reset_no_inc", n_sec2, 0);
    chk("held_btn_press", int'(state), 1);
    hold(0, 0, 0, 0, 0, 0, 8);

    // ---- randomized phase checked by the model every cycle ----
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 5)  == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 11) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 59) == 0) sw_adj    = ~sw_adj;
      if ($urandom_range(0, 19) == 0) sw_sel    = ~sw_sel;
      if ($urandom_range(0, 4)  == 0) clk_1Hz   = ~clk_1Hz;
      if ($urandom_range(0, 2)  == 0) clk_2Hz   = ~clk_2Hz;
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
